// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arb_mux stream multiplexer.
package mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    function automatic int sel_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Round-robin grant: first requester strictly after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    gnt
);

    always_comb begin
        logic found;
        int   idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-input stream multiplexer with a registered output slot; the source is picked
// by an explicit select (MODE_SEL) or by round-robin arbitration (MODE_RR).
module arb_mux
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    parameter  int MODE  = MODE_SEL,
    localparam int SELW  = sel_w(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SELW-1:0]      sel,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_src,
    input  logic                 out_ready
);

    out_state_e        state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [SELW-1:0]   src_q, src_d;
    logic [N-1:0]      grant;
    logic [SELW-1:0]   grant_idx;
    logic              can_load;
    logic              load;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SELW-1:0] ptr_q;

            rr_arbiter #(
                .N    (N),
                .SELW (SELW)
            ) u_arb (
                .req (in_valid),
                .ptr (ptr_q),
                .gnt (grant)
            );

            // ptr records the last accepted channel so the search resumes after it.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ptr_q <= SELW'(N - 1);
                end else if (load) begin
                    ptr_q <= grant_idx;
                end
            end
        end else begin : g_sel
            always_comb begin
                grant = '0;
                if (int'(sel) < N) begin
                    grant[sel] = in_valid[sel];
                end
            end
        end
    endgenerate

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx = SELW'(i);
            end
        end
    end

    assign can_load = (state_q == ST_EMPTY) || out_ready;
    assign in_ready = rst_n ? (grant & {N{can_load}}) : '0;
    assign load     = |in_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        if (load) begin
            state_d = ST_FULL;
            data_d  = in_data[grant_idx*WIDTH +: WIDTH];
            src_d   = grant_idx;
        end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;

endmodule
